// File: rtl/ssm_balance_fifo.sv
// Per-substream balance FIFO: 128-bit show-ahead word buffer that releases the
// substream parser (start_dec) once START_WORDS words are buffered.
module ssm_balance_fifo #(
  parameter int SSM_IDX     = 0,
  parameter int DEPTH       = 8,
  parameter int START_WORDS = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   in_vld,
  input  logic [127:0]           in_data,
  output logic                   in_rdy,
  input  logic                   codec_data_rd_en,
  output logic [127:0]           codec_data,
  output logic                   start_dec,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   underflow,
  output logic [1:0]             dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (SSM_IDX < 0 || DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 ||
      START_WORDS < 1 || START_WORDS > DEPTH) begin : g_bad_params
    $error("ssm_balance_fifo: illegal parameter set");
  end

  // dbg_state encoding: IDLE=0, FILL=1, RUN=2, ERR=3
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, ERR = 2'd3} state_t;

  // Handshake: a word moves in on a rising edge with in_vld & in_rdy; a word is
  // popped on a rising edge with codec_data_rd_en & (fifo_cnt > 0), and the
  // popped word is the one shown on codec_data during that same cycle.
  logic [127:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uf_q, uf_d, start_q, start_d;
  state_t           state_q, state_d;
  logic             wr_en, pop_en, uf_evt;

  assign in_rdy     = cnt_q < CNT_W'(DEPTH);
  assign codec_data = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign fifo_cnt   = cnt_q;
  assign underflow  = uf_q;
  assign start_dec  = start_q;
  assign dbg_state  = state_q;

  always_comb begin
    wr_en    = in_vld & in_rdy & ~flush;
    pop_en   = codec_data_rd_en & (cnt_q != '0);
    uf_evt   = codec_data_rd_en & (cnt_q == '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    uf_d     = uf_q;
    state_d  = state_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      uf_d     = 1'b0;
      state_d  = IDLE;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, pop_en})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      if (uf_evt) uf_d = 1'b1;
      case (state_q)
        IDLE: if (wr_en) state_d = (cnt_d >= CNT_W'(START_WORDS)) ? RUN : FILL;
        FILL: if (cnt_d >= CNT_W'(START_WORDS)) state_d = RUN;
        RUN:  if (uf_evt) state_d = ERR;
        default: state_d = state_q;
      endcase
    end
    start_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      uf_q     <= 1'b0;
      start_q  <= 1'b0;
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      uf_q     <= uf_d;
      start_q  <= start_d;
      state_q  <= state_d;
    end
  end

  // Storage is deliberately never cleared; count and pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_ssm_balance_fifo.sv
// Self-checking bench for ssm_balance_fifo: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
module tb_ssm_balance_fifo;

  localparam int DEPTH = 8;
  localparam int START = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          in_vld = 1'b0;
  logic [127:0]  in_data = '0;
  logic          in_rdy;
  logic          rd_en = 1'b0;
  logic [127:0]  codec_data;
  logic          start_dec;
  logic [CW-1:0] fifo_cnt;
  logic          underflow;
  logic [1:0]    dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  ssm_balance_fifo #(.SSM_IDX(3), .DEPTH(DEPTH), .START_WORDS(START)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_vld(in_vld), .in_data(in_data),
    .in_rdy(in_rdy), .codec_data_rd_en(rd_en), .codec_data(codec_data),
    .start_dec(start_dec), .fifo_cnt(fifo_cnt), .underflow(underflow),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [127:0] mq[$];
  bit m_wrote, m_run, m_err, m_uf;

  always @(posedge clk or negedge rstn) begin
    bit w, p, u;
    int sz;
    if (!rstn) begin
      mq.delete();
      m_wrote = 0; m_run = 0; m_err = 0; m_uf = 0;
    end else if (flush) begin
      mq.delete();
      m_wrote = 0; m_run = 0; m_err = 0; m_uf = 0;
    end else begin
      sz = mq.size();
      w = in_vld && (sz < DEPTH);
      p = rd_en && (sz > 0);
      u = rd_en && (sz == 0);
      if (p) void'(mq.pop_front());
      if (w) begin
        mq.push_back(in_data);
        m_wrote = 1;
      end
      if (u) m_uf = 1;
      if (u && m_run) m_err = 1;
      if (!m_run && !m_err && m_wrote && mq.size() >= START) m_run = 1;
    end
  end

  function automatic logic [1:0] exp_state();
    if (m_err) return 2'd3;
    if (m_run) return 2'd2;
    if (m_wrote) return 2'd1;
    return 2'd0;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_in_rdy", 128'(in_rdy), 128'(mq.size() < DEPTH));
    chk("m_fifo_cnt", 128'(fifo_cnt), 128'(mq.size()));
    chk("m_codec_data", codec_data, (mq.size() > 0) ? mq[0] : 128'd0);
    chk("m_start_dec", 128'(start_dec), 128'(m_run && !m_err));
    chk("m_underflow", 128'(underflow), 128'(m_uf));
    chk("m_state", 128'(dbg_state), 128'(exp_state()));
  end

  // ---------------- driver ----------------
  // Called at posedge+2; applies inputs for one edge, returns at next posedge+2.
  task automatic cyc(input bit v, input logic [127:0] d, input bit r, input bit f);
    in_vld = v; in_data = d; rd_en = r; flush = f;
    @(posedge clk); #2;
    in_vld = 0; rd_en = 0; flush = 0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_rdy"}, 128'(in_rdy), 128'd1);
    chk({tag, "_cnt"}, 128'(fifo_cnt), 128'd0);
    chk({tag, "_codec"}, codec_data, 128'd0);
    chk({tag, "_start"}, 128'(start_dec), 128'd0);
    chk({tag, "_uf"}, 128'(underflow), 128'd0);
    chk({tag, "_state"}, 128'(dbg_state), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] wa, wb, wz, ww, r1, r2;
    wa = {32{4'hA}};
    wb = {32{4'hB}};
    wz = {32{4'h5}};
    #1;
    chk_reset_outs("por");
    @(posedge clk); @(posedge clk); #2;
    rstn = 1;

    // Release after START words
    cyc(1, wa, 0, 0);
    chk("first_wr_cnt", 128'(fifo_cnt), 128'd1);
    chk("first_wr_start", 128'(start_dec), 128'd0);
    cyc(1, wb, 0, 0);
    chk("second_wr_start", 128'(start_dec), 128'd1);
    chk("second_wr_codec", codec_data, wa);
    chk("second_wr_cnt", 128'(fifo_cnt), 128'd2);

    // Fill to full, overflow attempt, one pop
    for (int i = 0; i < 6; i++) cyc(1, rnd128(), 0, 0);
    chk("full_cnt", 128'(fifo_cnt), 128'd8);
    chk("full_rdy", 128'(in_rdy), 128'd0);
    cyc(1, rnd128(), 0, 0);
    chk("ovf_cnt", 128'(fifo_cnt), 128'd8);
    cyc(0, '0, 1, 0);
    chk("pop_rdy", 128'(in_rdy), 128'd1);
    chk("pop_codec", codec_data, wb);
    cyc(1, rnd128(), 0, 0);
    cyc(1, rnd128(), 1, 0);
    chk("full_wr_pop_cnt", 128'(fifo_cnt), 128'd7);

    // Streaming at count 3 across pointer wrap
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0);
    chk("drain3_cnt", 128'(fifo_cnt), 128'd3);
    for (int i = 0; i < 20; i++) begin
      cyc(1, rnd128(), 1, 0);
      chk("stream_cnt", 128'(fifo_cnt), 128'd3);
    end

    // Underflow in RUN
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);
    chk("empty_start", 128'(start_dec), 128'd1);
    cyc(0, '0, 1, 0);
    chk("uf_flag", 128'(underflow), 128'd1);
    chk("uf_state", 128'(dbg_state), 128'd3);
    chk("uf_start", 128'(start_dec), 128'd0);
    chk("uf_codec", codec_data, 128'd0);
    cyc(1, rnd128(), 0, 0);
    chk("err_wr_cnt", 128'(fifo_cnt), 128'd1);
    chk("err_wr_start", 128'(start_dec), 128'd0);

    // Flush dominates write and pop
    cyc(0, '0, 0, 1);
    chk("flush_state", 128'(dbg_state), 128'd0);
    for (int i = 0; i < 5; i++) cyc(1, rnd128(), 0, 0);
    chk("pre_flush_cnt", 128'(fifo_cnt), 128'd5);
    cyc(1, wz, 1, 1);
    chk("flush_cnt", 128'(fifo_cnt), 128'd0);
    chk("flush_uf", 128'(underflow), 128'd0);
    chk("flush_start", 128'(start_dec), 128'd0);
    chk("flush_codec", codec_data, 128'd0);
    ww = rnd128();
    cyc(1, ww, 0, 0);
    chk("post_flush_head", codec_data, ww);
    chk("post_flush_cnt", 128'(fifo_cnt), 128'd1);

    // Mid-stream asynchronous reset
    for (int i = 0; i < 3; i++) cyc(1, rnd128(), 0, 0);
    chk("pre_rst_cnt", 128'(fifo_cnt), 128'd4);
    #1 rstn = 0;
    #1 chk_reset_outs("mid_rst");
    @(posedge clk); #2;
    rstn = 1;
    r1 = rnd128();
    r2 = rnd128();
    cyc(1, r1, 0, 0);
    cyc(1, r2, 0, 0);
    chk("refill_start", 128'(start_dec), 128'd1);
    chk("refill_codec", codec_data, r1);
    chk("refill_cnt", 128'(fifo_cnt), 128'd2);

    // Random traffic with alternating fill/drain bias
    for (int i = 0; i < 600; i++) begin
      bit v, r, f;
      if ((i / 50) % 2 == 0) begin
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        v = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      f = ($urandom_range(0, 79) == 0);
      cyc(v, rnd128(), r, f);
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
